// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered scan multiplexer.
// Mode encoding and select wrap are kept here so every user agrees on them.
package mux_pkg;

    localparam int MAX_CHANNELS = 16;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Next channel in round-robin order; wraps at n-1 even when n is not a power of two.
    function automatic int unsigned wrap_inc(input int unsigned sel, input int unsigned n);
        if (sel >= n - 1) begin
            return 0;
        end
        return sel + 1;
    endfunction

endpackage

// File: rtl/mux_scan_sel_tick_gen.sv
// Dwell counter: raises tick combinationally in the cycle the count reaches DWELL-1.
// clr or a dropped en restart a full dwell from zero.
module tick_gen #(
    parameter int DWELL = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel, W-bit mux with manual select and round-robin auto-scan.
// All outputs are registered; tick is high in the cycle cur_sel shows the advanced channel.
module mux_scan_sel
    import mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 50_000_000
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      load,
    input  logic                      scan_en,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_err,
    output logic                      tick
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             tick_q, tick_d;
    logic             mode;
    logic             sel_ok;
    logic             load_ok;
    logic             adv;

    assign mode    = scan_en ? MODE_SCAN : MODE_MANUAL;
    assign sel_ok  = {1'b0, sel_in} < CH_LIMIT;
    assign load_ok = load && sel_ok;

    // A valid load restarts the dwell so scanning resumes from the loaded channel.
    tick_gen #(
        .DWELL (DWELL)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .en       (mode == MODE_SCAN),
        .clr      (load_ok),
        .tick     (adv)
    );

    always_comb begin
        sel_d  = sel_q;
        err_d  = err_q;
        tick_d = 1'b0;
        data_d = data_in[int'(sel_q)*WIDTH +: WIDTH];
        if (load && !sel_ok) begin
            err_d = 1'b1;
        end
        if (load_ok) begin
            sel_d = sel_in;
        end else if (adv) begin
            sel_d  = SEL_W'(wrap_inc(32'(sel_q), CHANNELS));
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sel_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            data_q <= data_d;
            err_q  <= err_d;
            tick_q <= tick_d;
        end
    end

    assign data_out = data_q;
    assign cur_sel  = sel_q;
    assign sel_err  = err_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: a 3-channel/DWELL=3 and a 4-channel/DWELL=1 instance share stimulus.
// A behavioural model feeds per-instance expected queues; directed literals pin the model.
module tb_mux_scan_sel;

    logic        clk;
    logic        resetn;
    logic [15:0] data_in;
    logic [1:0]  sel_in;
    logic        load;
    logic        scan_en;

    logic [3:0] a_data, b_data;
    logic [1:0] a_sel, b_sel;
    logic       a_err, b_err, a_tick, b_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    int m_sel[2];
    int m_left[2];
    int m_err[2];
    int m_tick[2];
    int m_data[2];
    bit started = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    mux_scan_sel #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u_a (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .data_in  (data_in[11:0]),
        .sel_in   (sel_in),
        .load     (load),
        .scan_en  (scan_en),
        .data_out (a_data),
        .cur_sel  (a_sel),
        .sel_err  (a_err),
        .tick     (a_tick)
    );

    mux_scan_sel #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u_b (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .data_in  (data_in),
        .sel_in   (sel_in),
        .load     (load),
        .scan_en  (scan_en),
        .data_out (b_data),
        .cur_sel  (b_sel),
        .sel_err  (b_err),
        .tick     (b_tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining-dwell countdown per instance, modulo channel wrap.
    always @(posedge clk) begin
        int ch;
        int dw;
        for (int i = 0; i < 2; i++) begin
            ch = (i == 0) ? 3 : 4;
            dw = (i == 0) ? 3 : 1;
            if (!resetn) begin
                m_sel[i]  = 0;
                m_err[i]  = 0;
                m_tick[i] = 0;
                m_data[i] = 0;
                m_left[i] = dw;
            end else begin
                m_data[i] = int'((data_in >> (m_sel[i] * 4)) & 16'h000F);
                m_tick[i] = 0;
                if (load && int'(sel_in) >= ch) m_err[i] = 1;
                if (load && int'(sel_in) < ch) begin
                    m_sel[i]  = int'(sel_in);
                    m_left[i] = dw;
                end else if (scan_en) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_sel[i]  = (m_sel[i] + 1) % ch;
                        m_tick[i] = 1;
                        m_left[i] = dw;
                    end
                end else begin
                    m_left[i] = dw;
                end
            end
        end
        if (!resetn) started = 1;
        if (started) begin
            exp_q_a.push_back({m_tick[0][0], m_err[0][0], m_sel[0][1:0], m_data[0][3:0]});
            exp_q_b.push_back({m_tick[1][0], m_err[1][0], m_sel[1][1:0], m_data[1][3:0]});
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (exp_q_a.size() > 0) begin
            e = exp_q_a.pop_front();
            chk("a.data_out", int'(a_data), int'(e[3:0]));
            chk("a.cur_sel", int'(a_sel), int'(e[5:4]));
            chk("a.sel_err", int'(a_err), int'(e[6]));
            chk("a.tick", int'(a_tick), int'(e[7]));
        end
        if (exp_q_b.size() > 0) begin
            e = exp_q_b.pop_front();
            chk("b.data_out", int'(b_data), int'(e[3:0]));
            chk("b.cur_sel", int'(b_sel), int'(e[5:4]));
            chk("b.sel_err", int'(b_err), int'(e[6]));
            chk("b.tick", int'(b_tick), int'(e[7]));
        end
    end

    initial begin
        resetn  = 1'b0;
        data_in = 16'($urandom);
        load    = 1'b1;
        sel_in  = 2'($urandom_range(0, 3));
        scan_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.data", int'(a_data), 0);
        chk("rst.sel", int'(a_sel), 0);
        chk("rst.err", int'(a_err), 0);
        chk("rst.tick", int'(a_tick), 0);
        chk("rst.b_tick", int'(b_tick), 0);

        // Manual select
        resetn  = 1'b1;
        scan_en = 1'b0;
        data_in = 16'hD9A5;
        load    = 1'b1;
        sel_in  = 2'd2;
        @(negedge clk);
        chk("man.sel2", int'(a_sel), 2);
        load = 1'b0;
        @(negedge clk);
        chk("man.data9", int'(a_data), 9);
        chk("man.b_data9", int'(b_data), 9);
        load   = 1'b1;
        sel_in = 2'd0;
        @(negedge clk);
        load = 1'b0;
        chk("man.sel0", int'(a_sel), 0);
        @(negedge clk);
        chk("man.data5", int'(a_data), 5);

        // Invalid select on the 3-channel instance only
        load   = 1'b1;
        sel_in = 2'd3;
        @(negedge clk);
        chk("inv.sel_hold", int'(a_sel), 0);
        chk("inv.err", int'(a_err), 1);
        chk("inv.b_err", int'(b_err), 0);
        chk("inv.b_sel3", int'(b_sel), 3);
        sel_in = 2'd1;
        @(negedge clk);
        chk("inv.err_sticky", int'(a_err), 1);
        chk("inv.sel1", int'(a_sel), 1);

        // Auto-scan wrap from channel 0
        sel_in = 2'd0;
        @(negedge clk);
        load    = 1'b0;
        scan_en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chk("scan.sel", int'(a_sel), (k / 3) % 3);
            chk("scan.tick", int'(a_tick), (k % 3 == 0) ? 1 : 0);
            if (k == 1) begin
                chk("scan.b_tick", int'(b_tick), 1);
                chk("scan.b_sel", int'(b_sel), 1);
            end
        end

        // Load in the cycle the advance would occur
        load   = 1'b1;
        sel_in = 2'd1;
        @(negedge clk);
        load = 1'b0;
        chk("lds.sel", int'(a_sel), 1);
        chk("lds.tick", int'(a_tick), 0);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("lds.resume_sel", int'(a_sel), (j == 3) ? 2 : 1);
            chk("lds.resume_tick", int'(a_tick), (j == 3) ? 1 : 0);
        end

        // Mode drop at channel 2
        scan_en = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("drop.sel", int'(a_sel), 2);
            chk("drop.tick", int'(a_tick), 0);
        end

        // Reset in the middle of a scan
        scan_en = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("mrst.data", int'(a_data), 0);
        chk("mrst.sel", int'(a_sel), 0);
        chk("mrst.err", int'(a_err), 0);
        chk("mrst.tick", int'(a_tick), 0);
        chk("mrst.b_tick", int'(b_tick), 0);
        resetn = 1'b1;

        // Randomised traffic against the model
        repeat (3000) begin
            data_in = 16'($urandom);
            load    = ($urandom_range(0, 7) == 0);
            sel_in  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) scan_en = ~scan_en;
            resetn  = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end

        resetn = 1'b1;
        load   = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
# mux_scan_sel

Registered, parametrised N-channel, W-bit-wide multiplexer. It is the successor to the lab 2:1 4-bit switch mux: any channel count and width, a registered select, and an auto-scan mode that steps round-robin through channels at a programmable dwell rate. It sits between the switch/input fabric and the LED/display drivers and presents one selected word per cycle.

## Interface

**Parameters**
- `WIDTH`, 4: bits per channel.
- `CHANNELS`, 4: number of input channels, 2 to 16.
- `SEL_W`, `$clog2(CHANNELS)`: select width (derived, not overridden).
- `DWELL`, 50_000_000: cycles per channel in auto-scan, ≥1.

**Ports**
- `CLOCK_50`, in, 1: single clock, rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `data_in`, in, `CHANNELS*WIDTH`: channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `sel_in`, in, `SEL_W`: manual channel request.
- `load`, in, 1: capture `sel_in` this cycle.
- `scan_en`, in, 1: 1 = auto-scan mode, 0 = manual mode.
- `data_out`, out, `WIDTH`: registered selected word.
- `cur_sel`, out, `SEL_W`: channel currently driving `data_out`.
- `sel_err`, out, 1: sticky flag; set when `load` carries `sel_in ≥ CHANNELS`.
- `tick`, out, 1: one-cycle pulse on every auto-scan advance.

## Operation

- **Reset** (`resetn`=0 at a clock edge): `data_out`=0, `cur_sel`=0, `sel_err`=0, `tick`=0, dwell counter=0. Reset is honoured mid-scan and mid-load, and overrides all other inputs.
- **Select register** `sel_q` drives `cur_sel`. Each cycle `data_out <= data_in[sel_q]`, using the select value in effect at that edge.
- **Manual mode** (`scan_en`=0):
  - `load`=1 with `sel_in < CHANNELS` sets `sel_q <= sel_in`.
  - `load`=1 with `sel_in ≥ CHANNELS` leaves `sel_q` unchanged and sets `sel_err`.
  - The dwell counter is held at 0.
- **Auto-scan mode** (`scan_en`=1):
  - The dwell counter increments every cycle.
  - At `DWELL-1` the counter returns to 0, `sel_q` advances to `sel_q+1`, and `tick` pulses. `sel_q` wraps from `CHANNELS-1` to 0, including when `CHANNELS` is not a power of two.
- **Load and scan together:** a valid `load` overrides the advance in that cycle. `sel_q <= sel_in`, the counter clears to 0, and `tick` stays 0, so scanning resumes from the loaded channel with a full dwell.
- **Mode switches:**
  - Leaving scan mode freezes `sel_q` at its current value and clears the counter.
  - Entering scan mode starts a full dwell from the current `sel_q`.
- **`sel_err`** clears only on reset.
- **`DWELL`=1:** advance every cycle, with `tick` held high continuously while scanning.

## Timing

- Data latency: 1 cycle from `data_in` to `data_out` for a fixed select.
- Select latency:
  - A `load` at edge n updates `cur_sel` at edge n.
  - `data_out` reflects the new channel at edge n+1.
- Scan period: `cur_sel` changes every `DWELL` cycles. `tick` is asserted during the same cycle in which `cur_sel` shows the new value.
- No combinational path from inputs to outputs.

## Structure

- Shared package `mux_pkg`:
  - `MAX_CHANNELS` = 16.
  - `function automatic` helper for select wrap.
  - Mode encoding localparams `MODE_MANUAL`=0 and `MODE_SCAN`=1.
- One sub-module, `tick_gen`:
  - Parameter `DWELL`.
  - Ports `CLOCK_50`, `resetn`, `en`, `clr`, `tick`.
  - Counter width `$clog2(DWELL)`, minimum 1.
- The top level contains the select register, error flag, and output mux/register.

## Test plan

1. **Reset:** assert `resetn`=0 for 2 cycles with arbitrary inputs → `data_out`=0, `cur_sel`=0, `sel_err`=0, `tick`=0.
2. **Manual select:** `WIDTH`=4, `CHANNELS`=4, `data_in`=16'hD9A5, `load` with `sel_in`=2 → `cur_sel`=2 the same edge, `data_out`=4'h9 the next edge; `sel_in`=0 → `data_out`=4'h5.
3. **Invalid select:** `CHANNELS`=3, `load` with `sel_in`=3 → `cur_sel` unchanged, `sel_err`=1, and it stays 1 after a later valid load.
4. **Auto-scan wrap:** `DWELL`=3, `CHANNELS`=3, `scan_en`=1 from `cur_sel`=0 → `cur_sel` follows 1,2,0,1 every 3 cycles, with `tick` pulsing exactly once per step.
5. **Load during scan:** `DWELL`=4, pulse `load` (`sel_in`=1) in the cycle the advance would occur → `cur_sel`=1, no `tick`, next advance to 2 exactly 4 cycles later.
6. **Mid-scan reset and mode drop:** reset during scan → all outputs 0 the next edge. `scan_en` 1→0 at `cur_sel`=2 → `cur_sel` holds at 2 for 100 cycles.
